alu_rs: RTL

- ALU reservation station, directly downstream of dispatch.
- Dispatch writes renamed ALU ops (dispatch_pipeline_data plus fu code) into a small age-ordered buffer.
- Entries snoop writeback tags to mark sources ready.
- Each cycle, the oldest entry with both sources ready is offered to the ALU using a valid/ready handshake, as an alu_rs_data record.

---
 rtl/types_pkg.sv | 48 ++++
 rtl/alu_rs_select.sv | 28 ++
 rtl/alu_rs.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared pipeline types for the ALU reservation station.
// Holds the dispatch and issue bundles plus the source-ready helper.
package types_pkg;

    localparam int ALU_RS_DEPTH = 8;
    localparam int PREG_W = 8;

    typedef struct packed {
        logic [6:0]        Opcode;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic [PREG_W-1:0] pr2;
        logic [31:0]       imm;
        logic [3:0]        rob_index;
        logic              pr1_ready;
        logic              pr2_ready;
    } dispatch_pipeline_data;

    typedef struct packed {
        logic              valid;
        logic [6:0]        Opcode;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic              pr1_ready;
        logic [PREG_W-1:0] pr2;
        logic              pr2_ready;
        logic [31:0]       imm;
        logic [3:0]        rob_index;
        logic [1:0]        fu;
        logic [2:0]        age;
    } alu_rs_data;

    // A source is ready if already marked, is the zero register,
    // or is being produced on either writeback port right now.
    function automatic logic rs_src_ready(
        input logic [PREG_W-1:0] tag,
        input logic              rdy,
        input logic              wb0_valid,
        input logic [PREG_W-1:0] wb0_tag,
        input logic              wb1_valid,
        input logic [PREG_W-1:0] wb1_tag
    );
        return rdy || (tag == '0) ||
               (wb0_valid && (wb0_tag == tag)) ||
               (wb1_valid && (wb1_tag == tag));
    endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Oldest-ready picker: grants the eligible entry with the smallest age.
// Ages of valid entries are unique, so the grant is one-hot.
module alu_rs_select
    import types_pkg::*;
#(
    parameter int N = ALU_RS_DEPTH
) (
    input  logic [N-1:0]      elig,
    input  logic [N-1:0][2:0] age,
    output logic [N-1:0]      grant,
    output logic              found
);

    // An entry wins when no other eligible entry is older.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = elig[i];
            for (int j = 0; j < N; j++) begin
                if ((j != i) && elig[j] && (age[j] < age[i])) begin
                    grant[i] = 1'b0;
                end
            end
        end
        found = |elig;
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: age-ordered buffer with tag wakeup and issue.
// Optional macro ALU_RS_SAME_CYCLE_WAKEUP_EN enables 0-cycle wakeup-to-issue.
module alu_rs #(
    parameter int RS_DEPTH = types_pkg::ALU_RS_DEPTH,
    parameter int PREG_W   = types_pkg::PREG_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             disp_valid,
    input  types_pkg::dispatch_pipeline_data disp_data,
    input  logic [1:0]                       disp_fu,
    output logic                             disp_ready,
    input  logic                             wb0_valid,
    input  logic [PREG_W-1:0]                wb0_tag,
    input  logic                             wb1_valid,
    input  logic [PREG_W-1:0]                wb1_tag,
    output logic                             issue_valid,
    output types_pkg::alu_rs_data            issue_data,
    input  logic                             issue_ready,
    input  logic                             flush,
    output logic [3:0]                       rs_count
);

    types_pkg::alu_rs_data ent_q [RS_DEPTH];
    types_pkg::alu_rs_data new_ent;
    types_pkg::alu_rs_data sel;
    logic [3:0]                 count_q;
    logic [RS_DEPTH-1:0]        elig;
    logic [RS_DEPTH-1:0][2:0]   ages;
    logic [RS_DEPTH-1:0]        grant;
    logic [RS_DEPTH-1:0]        alloc_oh;
    logic                       found;
    logic                       hit;
    logic                       do_alloc;
    logic                       do_issue;

    // Eligibility per entry; the macro build also counts live broadcasts.
    always_comb begin
        elig = '0;
        ages = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ages[i] = ent_q[i].age;
`ifdef ALU_RS_SAME_CYCLE_WAKEUP_EN
            elig[i] = ent_q[i].valid &&
                types_pkg::rs_src_ready(ent_q[i].pr1, ent_q[i].pr1_ready,
                    wb0_valid, wb0_tag, wb1_valid, wb1_tag) &&
                types_pkg::rs_src_ready(ent_q[i].pr2, ent_q[i].pr2_ready,
                    wb0_valid, wb0_tag, wb1_valid, wb1_tag);
`else
            elig[i] = ent_q[i].valid && ent_q[i].pr1_ready &&
                      ent_q[i].pr2_ready;
`endif
        end
    end

    alu_rs_select #(
        .N(RS_DEPTH)
    ) u_select (
        .elig  (elig),
        .age   (ages),
        .grant (grant),
        .found (found)
    );

    // Mux out the granted entry; zeros when nothing is ready.
    always_comb begin
        sel = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) sel = ent_q[i];
        end
        if (found) begin
            sel.valid     = 1'b1;
            sel.pr1_ready = 1'b1;
            sel.pr2_ready = 1'b1;
        end
    end

    assign issue_data  = sel;
    assign issue_valid = found && !flush;
    assign disp_ready  = (count_q < 4'(RS_DEPTH));
    assign rs_count    = count_q;
    assign do_alloc    = disp_valid && disp_ready && !flush;
    assign do_issue    = issue_valid && issue_ready;

    // Lowest-index free slot for allocation.
    always_comb begin
        alloc_oh = '0;
        hit      = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!ent_q[i].valid && !hit) begin
                alloc_oh[i] = 1'b1;
                hit         = 1'b1;
            end
        end
    end

    // Build the incoming entry, catching same-cycle writebacks.
    always_comb begin
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.Opcode    = disp_data.Opcode;
        new_ent.prd       = disp_data.prd;
        new_ent.pr1       = disp_data.pr1;
        new_ent.pr2       = disp_data.pr2;
        new_ent.imm       = disp_data.imm;
        new_ent.rob_index = disp_data.rob_index;
        new_ent.fu        = disp_fu;
        new_ent.pr1_ready = types_pkg::rs_src_ready(disp_data.pr1,
            disp_data.pr1_ready, wb0_valid, wb0_tag, wb1_valid, wb1_tag);
        new_ent.pr2_ready = types_pkg::rs_src_ready(disp_data.pr2,
            disp_data.pr2_ready, wb0_valid, wb0_tag, wb1_valid, wb1_tag);
        new_ent.age       = 3'(count_q) - {2'b00, do_issue};
    end

    // Entry state: allocate, issue, wakeup, age compaction, flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (do_alloc && alloc_oh[i]) begin
                    ent_q[i] <= new_ent;
                end else if (do_issue && grant[i]) begin
                    ent_q[i] <= '0;
                end else if (ent_q[i].valid) begin
                    ent_q[i].pr1_ready <= types_pkg::rs_src_ready(
                        ent_q[i].pr1, ent_q[i].pr1_ready,
                        wb0_valid, wb0_tag, wb1_valid, wb1_tag);
                    ent_q[i].pr2_ready <= types_pkg::rs_src_ready(
                        ent_q[i].pr2, ent_q[i].pr2_ready,
                        wb0_valid, wb0_tag, wb1_valid, wb1_tag);
                    if (do_issue && (ent_q[i].age > sel.age)) begin
                        ent_q[i].age <= ent_q[i].age - 3'd1;
                    end
                end
            end
            count_q <= count_q + {3'b000, do_alloc} - {3'b000, do_issue};
        end
    end

endmodule
